// File: rtl/sdr_wb_arbiter_if.sv
// rtl/sdr_wb_arbiter_if.sv - Wishbone signal bundle between two masters, the arbiter and the SDRAM slave port
interface sdr_wb_arbiter_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic            m0_cyc_i, m0_stb_i, m0_we_i;
  logic [DW/8-1:0] m0_sel_i;
  logic [AW-1:0]   m0_adr_i;
  logic [DW-1:0]   m0_dat_i;
  logic [DW-1:0]   m0_dat_o;
  logic            m0_ack_o, m0_err_o;

  logic            m1_cyc_i, m1_stb_i, m1_we_i;
  logic [DW/8-1:0] m1_sel_i;
  logic [AW-1:0]   m1_adr_i;
  logic [DW-1:0]   m1_dat_i;
  logic [DW-1:0]   m1_dat_o;
  logic            m1_ack_o, m1_err_o;

  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [DW/8-1:0] s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i;

  // Environment view: the two masters plus the SDRAM controller.
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );

  // Arbiter view.
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i
  );
endinterface

// File: rtl/sdr_wb_arbiter.sv
// rtl/sdr_wb_arbiter.sv - two-master round-robin Wishbone arbiter with stall watchdog for the SDRAM slave port
module sdr_wb_arbiter #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  sdr_wb_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

  localparam logic [15:0] WDOG_MAX = 16'(TIMEOUT - 1);

  state_t      state;
  logic        last_grant;
  logic        err_owner;
  logic [15:0] wdog;

  logic gnt0, gnt1, stb_fwd, stall, timeout;

  always_comb begin
    gnt0    = (state == GNT0);
    gnt1    = (state == GNT1);
    stb_fwd = (gnt0 & bus.m0_stb_i) | (gnt1 & bus.m1_stb_i);
    stall   = stb_fwd & ~bus.s_ack_i;
    // Terminations are suppressed while reset is asserted so an aborted transfer never completes.
    timeout = stall & (wdog == WDOG_MAX) & ~wb_rst_i;
  end

  assign bus.s_cyc_o  = gnt0 | gnt1;
  assign bus.s_stb_o  = stb_fwd;
  assign bus.s_we_o   = gnt0 ? bus.m0_we_i  : (gnt1 ? bus.m1_we_i  : 1'b0);
  assign bus.s_sel_o  = gnt0 ? bus.m0_sel_i : (gnt1 ? bus.m1_sel_i : '0);
  assign bus.s_adr_o  = gnt0 ? bus.m0_adr_i : (gnt1 ? bus.m1_adr_i : '0);
  assign bus.s_dat_o  = gnt0 ? bus.m0_dat_i : (gnt1 ? bus.m1_dat_i : '0);

  assign bus.m0_ack_o = gnt0 & bus.m0_stb_i & bus.s_ack_i & ~wb_rst_i;
  assign bus.m1_ack_o = gnt1 & bus.m1_stb_i & bus.s_ack_i & ~wb_rst_i;
  assign bus.m0_err_o = gnt0 & timeout;
  assign bus.m1_err_o = gnt1 & timeout;
  assign bus.m0_dat_o = gnt0 ? bus.s_dat_i : '0;
  assign bus.m1_dat_o = gnt1 ? bus.s_dat_i : '0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      err_owner  <= 1'b0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_grant)) begin
            state      <= GNT0;
            last_grant <= 1'b0;
          end else if (bus.m1_cyc_i) begin
            state      <= GNT1;
            last_grant <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (timeout) begin
            state     <= ERR;
            err_owner <= gnt1;
            wdog      <= '0;
          end else if ((gnt0 && !bus.m0_cyc_i) || (gnt1 && !bus.m1_cyc_i)) begin
            state <= IDLE;
            wdog  <= '0;
          end else begin
            wdog <= stall ? wdog + 16'd1 : '0;
          end
        end
        ERR: begin
          wdog <= '0;
          // Owner must drop CYC to acknowledge the error before the bus is re-arbitrated.
          if ((err_owner ? bus.m1_cyc_i : bus.m0_cyc_i) == 1'b0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// tb/tb_sdr_wb_arbiter.sv - directed table-driven bench for sdr_wb_arbiter
module tb_sdr_wb_arbiter;
  localparam int AW = 26;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdr_wb_arbiter_if #(.AW(AW), .DW(DW)) bus();

  sdr_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct {
    logic        rst, c0, s0, w0, c1, s1, w1, ack;
    logic [31:0] sdat;
    logic [1:0]  g;
    logic        a0, a1;
  } vec_t;

  vec_t vecs[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic r, c0, s0, w0, c1, s1, w1, ack, input logic [31:0] sdat,
                   input logic [1:0] g, input logic a0, a1);
    vec_t x;
    x.rst = r; x.c0 = c0; x.s0 = s0; x.w0 = w0; x.c1 = c1; x.s1 = s1; x.w1 = w1;
    x.ack = ack; x.sdat = sdat; x.g = g; x.a0 = a0; x.a1 = a1;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, c0, s0, c1, s1, ack);
    rst = r;
    bus.m0_cyc_i = c0; bus.m0_stb_i = s0;
    bus.m1_cyc_i = c1; bus.m1_stb_i = s1;
    bus.s_ack_i = ack;
  endtask

  initial begin
    bus.m0_we_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m0_sel_i = 4'hF; bus.m1_sel_i = 4'h3;
    bus.m0_adr_i = 26'h0000100; bus.m1_adr_i = 26'h0000200;
    bus.m0_dat_i = 32'hA5A5A5A5; bus.m1_dat_i = 32'h5A5A5A5A;
    bus.s_dat_i = '0;
    drive(1, 0, 0, 0, 0, 0);

    //  rst c0 s0 w0 c1 s1 w1 ack sdat           g  a0 a1
    v(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0); // reset values
    v(0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         0, 0, 0); // single master write
    v(0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 1, 0, 0, 0, 1, 32'h0,         1, 1, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0); // tie after reset
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 1, 32'h77,        1, 1, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0, 1, 32'h88,        2, 0, 1);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         0, 0, 0); // repeated tie -> m0
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 1, 32'h11,        1, 1, 0); // locked burst
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 1, 32'h22,        1, 1, 0);
    v(0, 1, 1, 0, 1, 1, 0, 1, 32'h33,        1, 1, 0);
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 1, 32'h44,        1, 1, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    v(0, 0, 0, 0, 1, 1, 0, 0, 32'h0,         2, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         2, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD,      0, 0, 0); // stray ack in IDLE
    v(0, 0, 0, 0, 0, 0, 0, 1, 32'hBEEF,      0, 0, 0);
    v(0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0); // reset mid-transfer
    v(0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(1, 1, 1, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         0, 0, 0);
    v(0, 1, 1, 0, 1, 1, 0, 0, 32'h0,         1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) begin
      vec_t x;
      logic        es, ew;
      logic [3:0]  esel;
      logic [25:0] eadr;
      logic [31:0] edat;
      x = vecs[i];
      @(negedge clk);
      drive(x.rst, x.c0, x.s0, x.c1, x.s1, x.ack);
      bus.m0_we_i = x.w0; bus.m1_we_i = x.w1; bus.s_dat_i = x.sdat;
      #1;
      es   = (x.g == 1) ? x.s0 : (x.g == 2) ? x.s1 : 1'b0;
      ew   = (x.g == 1) ? x.w0 : (x.g == 2) ? x.w1 : 1'b0;
      esel = (x.g == 1) ? 4'hF : (x.g == 2) ? 4'h3 : 4'h0;
      eadr = (x.g == 1) ? 26'h100 : (x.g == 2) ? 26'h200 : 26'h0;
      edat = (x.g == 1) ? 32'hA5A5A5A5 : (x.g == 2) ? 32'h5A5A5A5A : 32'h0;
      chk($sformatf("v%0d s_cyc", i), 64'(bus.s_cyc_o), 64'(x.g != 0));
      chk($sformatf("v%0d s_stb", i), 64'(bus.s_stb_o), 64'(es));
      chk($sformatf("v%0d s_we", i),  64'(bus.s_we_o),  64'(ew));
      chk($sformatf("v%0d s_sel", i), 64'(bus.s_sel_o), 64'(esel));
      chk($sformatf("v%0d s_adr", i), 64'(bus.s_adr_o), 64'(eadr));
      chk($sformatf("v%0d s_dat", i), 64'(bus.s_dat_o), 64'(edat));
      chk($sformatf("v%0d m0_ack", i), 64'(bus.m0_ack_o), 64'(x.a0));
      chk($sformatf("v%0d m1_ack", i), 64'(bus.m1_ack_o), 64'(x.a1));
      chk($sformatf("v%0d m0_err", i), 64'(bus.m0_err_o), 64'd0);
      chk($sformatf("v%0d m1_err", i), 64'(bus.m1_err_o), 64'd0);
      chk($sformatf("v%0d m0_dat", i), 64'(bus.m0_dat_o), 64'((x.g == 1) ? x.sdat : 32'h0));
      chk($sformatf("v%0d m1_dat", i), 64'(bus.m1_dat_o), 64'((x.g == 2) ? x.sdat : 32'h0));
    end

    // Watchdog: m1 stalls with no ack, err must pulse exactly on the 8th stalled cycle.
    bus.s_dat_i = 32'hCAFE0000;
    @(negedge clk); drive(0, 0, 0, 1, 1, 0); #1;
    chk("to idle s_cyc", 64'(bus.s_cyc_o), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to stall%0d s_cyc", i), 64'(bus.s_cyc_o), 64'd1);
      chk($sformatf("to stall%0d m1_err", i), 64'(bus.m1_err_o), 64'(i == 8));
      chk($sformatf("to stall%0d m1_ack", i), 64'(bus.m1_ack_o), 64'd0);
    end
    // In ERR: stray ack ignored, m0 request not serviced.
    @(negedge clk); drive(0, 1, 1, 1, 1, 1); #1;
    chk("err s_cyc", 64'(bus.s_cyc_o), 64'd0);
    chk("err s_stb", 64'(bus.s_stb_o), 64'd0);
    chk("err m1_err", 64'(bus.m1_err_o), 64'd0);
    chk("err m1_ack", 64'(bus.m1_ack_o), 64'd0);
    chk("err m0_ack", 64'(bus.m0_ack_o), 64'd0);
    @(negedge clk); drive(0, 1, 1, 1, 1, 0); #1;
    chk("err hold s_cyc", 64'(bus.s_cyc_o), 64'd0);
    @(negedge clk); drive(0, 1, 1, 0, 0, 0); #1;
    chk("err release s_cyc", 64'(bus.s_cyc_o), 64'd0);
    @(negedge clk); #1;
    chk("post err idle s_cyc", 64'(bus.s_cyc_o), 64'd0);
    @(negedge clk); drive(0, 1, 1, 1, 1, 0); #1;
    chk("post err m0 s_cyc", 64'(bus.s_cyc_o), 64'd1);
    chk("post err m0 s_adr", 64'(bus.s_adr_o), 64'h100);

    // Back-to-back: m0 drops CYC for one cycle while m1 waits, m1 wins.
    @(negedge clk); drive(0, 0, 0, 1, 1, 0); #1;
    chk("b2b release s_cyc", 64'(bus.s_cyc_o), 64'd1);
    @(negedge clk); drive(0, 1, 1, 1, 1, 0); #1;
    chk("b2b idle s_cyc", 64'(bus.s_cyc_o), 64'd0);
    @(negedge clk); drive(0, 1, 1, 1, 1, 1); #1;
    chk("b2b m1 s_adr", 64'(bus.s_adr_o), 64'h200);
    chk("b2b m1_ack", 64'(bus.m1_ack_o), 64'd1);
    chk("b2b m0_ack", 64'(bus.m0_ack_o), 64'd0);
    chk("b2b m1_dat", 64'(bus.m1_dat_o), 64'hCAFE0000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
